// File: rtl/mdu_pkg.sv
// Shared operation/state encodings and constants for the iterative multiply/divide unit.
package mdu_pkg;

  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUSY  = 2'b01,
    FINAL = 2'b10,
    DONE  = 2'b11
  } mdu_state_t;

  localparam logic [4:0] LO_ADDR = 5'b10001;
  localparam int         STEPS   = 32;

endpackage

// File: rtl/mdu_sign_cond.sv
// Absolute value / conditional two's-complement negate; purely combinational.
// Zero latency, no flow control.
module mdu_sign_cond #(
  parameter int W = 32
) (
  input  logic [W-1:0] din,
  input  logic         abs_en,
  input  logic         neg_en,
  output logic [W-1:0] dout
);

  logic flip;

  assign flip = neg_en | (abs_en & din[W-1]);
  assign dout = flip ? ((~din) + W'(1)) : din;

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide writing lo/hi with one ld_reg pulse; 34 cycles after accept (2 on divide by zero).
// No backpressure: start is only taken in IDLE and ignored while busy.
module mdu_iter #(
  parameter int         WIDTH   = 32,
  parameter logic [4:0] LO_ADDR = mdu_pkg::LO_ADDR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             ld_reg,
  output logic [4:0]       dr,
  output logic [WIDTH-1:0] lo_out,
  output logic [WIDTH-1:0] hi_out
);

  import mdu_pkg::*;

  localparam int            CW   = $clog2(STEPS);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  mdu_state_t         state, state_nxt;
  mdu_op_t            op_in, op_q;
  logic [CW-1:0]      counter;
  logic               neg_res, neg_rem;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc, acc_step, res, prod_fix;
  logic [WIDTH-1:0]   a_mag, b_mag, quo_fix, rem_fix;
  logic               op_signed, op_div, div_zero, sgn_a, sgn_b, is_div;
  logic [WIDTH:0]     mul_sum, div_shift;
  logic [WIDTH+1:0]   div_diff;

  assign op_in     = mdu_op_t'(op);
  assign op_signed = (op_in == MULT) || (op_in == DIV);
  assign op_div    = (op_in == DIV) || (op_in == DIVU);
  assign div_zero  = op_div && (opb == '0);
  assign sgn_a     = op_signed & opa[WIDTH-1];
  assign sgn_b     = op_signed & opb[WIDTH-1];
  assign is_div    = (op_q == DIV) || (op_q == DIVU);
  assign dr        = LO_ADDR;

  mdu_sign_cond #(.W(WIDTH)) u_abs_a (
    .din(opa), .abs_en(op_signed), .neg_en(1'b0), .dout(a_mag)
  );
  mdu_sign_cond #(.W(WIDTH)) u_abs_b (
    .din(opb), .abs_en(op_signed), .neg_en(1'b0), .dout(b_mag)
  );
  mdu_sign_cond #(.W(2*WIDTH)) u_fix_prod (
    .din(acc), .abs_en(1'b0), .neg_en(neg_res), .dout(prod_fix)
  );
  mdu_sign_cond #(.W(WIDTH)) u_fix_quo (
    .din(acc[WIDTH-1:0]), .abs_en(1'b0), .neg_en(neg_res), .dout(quo_fix)
  );
  mdu_sign_cond #(.W(WIDTH)) u_fix_rem (
    .din(acc[2*WIDTH-1:WIDTH]), .abs_en(1'b0), .neg_en(neg_rem), .dout(rem_fix)
  );

  // acc holds {hi, lo}: partial product and multiplier, or partial remainder and quotient.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opnd};
    acc_step  = {mul_sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (div_diff[WIDTH+1]) acc_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else                   acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
    res = is_div ? {rem_fix, quo_fix} : prod_fix;
  end

  // Divide by zero skips the steps but still spends one cycle in FINAL.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = div_zero ? FINAL : BUSY;
      BUSY:    if (counter == LAST) state_nxt = FINAL;
      FINAL:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      op_q    <= MULT;
      counter <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      opnd    <= '0;
      acc     <= '0;
      busy    <= 1'b0;
      ld_reg  <= 1'b0;
      lo_out  <= '0;
      hi_out  <= '0;
    end else begin
      state  <= state_nxt;
      busy   <= (state_nxt != IDLE);
      ld_reg <= (state_nxt == DONE);
      case (state)
        IDLE: if (start) begin
          op_q    <= op_in;
          counter <= '0;
          if (div_zero) begin
            // Sign flags cleared so FINAL passes {opa, all-ones} straight through.
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            acc     <= {opa, {WIDTH{1'b1}}};
          end else begin
            neg_res <= sgn_a ^ sgn_b;
            neg_rem <= sgn_a;
            opnd    <= op_div ? b_mag : a_mag;
            acc     <= {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
          end
        end
        BUSY: begin
          acc     <= acc_step;
          counter <= counter + CW'(1);
        end
        FINAL: begin
          lo_out <= res[WIDTH-1:0];
          hi_out <= res[2*WIDTH-1:WIDTH];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: directed vectors plus random ops against a native-arithmetic model.
module tb_mdu_iter;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [1:0]  op;
  logic [31:0] opa, opb;
  logic        busy, ld_reg;
  logic [4:0]  dr;
  logic [31:0] lo_out, hi_out;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    int          acc_cyc;
    int          lat;
    int          tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0, errors = 0, cyc = 0;
  int   n_acc = 0, n_ld = 0, n_abort = 0;
  logic prev_ld = 1'b0;

  mdu_iter dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .opa(opa), .opb(opb),
    .busy(busy), .ld_reg(ld_reg), .dr(dr), .lo_out(lo_out), .hi_out(hi_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic summary();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sbv, q, r;
    sa  = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    case (o)
      2'd0: return sa * sbv;
      2'd1: return {32'b0, a} * {32'b0, b};
      2'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sbv;
        r = sa % sbv;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Entered and left on a falling edge; the expected result is queued at the accepting edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] lo_e, input logic [31:0] hi_e, input int lat, input int tag);
    exp_t e;
    int   guard;
    guard = 0;
    while (busy !== 1'b0) begin
      @(negedge clk);
      guard++;
      if (guard > 100) begin
        checks++;
        errors++;
        $display("FAIL issue_wait tag %0d: busy=%b after %0d cycles, required 0", tag, busy, guard);
        summary();
      end
    end
    start = 1'b1;
    op    = o;
    opa   = a;
    opb   = b;
    @(posedge clk);
    #1;
    e.lo      = lo_e;
    e.hi      = hi_e;
    e.acc_cyc = cyc;
    e.lat     = lat;
    e.tag     = tag;
    exp_q.push_back(e);
    n_acc++;
    start = 1'b0;
    op    = 2'($urandom);
    opa   = $urandom;
    opb   = $urandom;
    check($sformatf("busy_after_accept tag %0d", tag), 64'(busy), 64'd1);
    @(negedge clk);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (prev_ld) check("ld_single_and_busy_fall", 64'({ld_reg, busy}), 64'd0);
    prev_ld = ld_reg;
    if (ld_reg === 1'b1) begin
      n_ld++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ld_reg at cycle %0d: ld_reg=1, required 0", cyc);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("lo_out tag %0d", e.tag), 64'(lo_out), 64'(e.lo));
        check($sformatf("hi_out tag %0d", e.tag), 64'(hi_out), 64'(e.hi));
        check($sformatf("dr tag %0d", e.tag), 64'(dr), 64'h11);
        check($sformatf("latency tag %0d", e.tag), 64'(cyc - e.acc_cyc + 1), 64'(e.lat));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  o;
    logic [31:0] a, b;
    logic [63:0] r;
    int          guard;

    reset = 1'b1;
    start = 1'b0;
    op    = 2'd0;
    opa   = 32'd0;
    opb   = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_ld_reg", 64'(ld_reg), 64'd0);
    check("reset_dr", 64'(dr), 64'h11);
    check("reset_lo", 64'(lo_out), 64'd0);
    check("reset_hi", 64'(hi_out), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 34, 1);
    issue(MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFEB, 32'hFFFF_FFFF, 34, 2);
    issue(DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 34, 3);
    issue(DIVU,  32'd7,         32'd2,         32'd3,         32'd1,         34, 4);
    issue(DIVU,  32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,         2,  5);
    issue(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         34, 6);
    issue(MULTU, 32'h1234_5678, 32'd0,         32'd0,         32'd0,         34, 7);
    issue(DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFB, 2,  8);
    issue(MULT,  32'h8000_0000, 32'h8000_0000, 32'd0,         32'h4000_0000, 34, 9);
    issue(DIV,   32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         34, 10);

    // A start in cycle 5 of a multiply must be dropped.
    issue(MULTU, 32'd3, 32'd4, 32'd12, 32'd0, 34, 20);
    repeat (4) @(negedge clk);
    start = 1'b1;
    op    = DIVU;
    opa   = 32'd9;
    opb   = 32'd0;
    @(negedge clk);
    start = 1'b0;

    // Reset in cycle 10 aborts the divide with no writeback.
    issue(DIV, 32'd100, 32'd7, 32'd14, 32'd2, 34, 21);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_ld_reg", 64'(ld_reg), 64'd0);
    check("abort_lo", 64'(lo_out), 64'd0);
    check("abort_hi", 64'(hi_out), 64'd0);
    exp_q.delete();
    n_abort++;
    reset = 1'b0;
    @(negedge clk);
    issue(DIVU, 32'd100, 32'd7, 32'd14, 32'd2, 34, 22);

    for (int i = 0; i < 1000; i++) begin
      o = 2'($urandom_range(0, 3));
      a = pick();
      b = pick();
      r = model(o, a, b);
      issue(o, a, b, r[31:0], r[63:32], (o[1] && b == 32'd0) ? 2 : 34, 100 + i);
    end

    guard = 0;
    while (exp_q.size() != 0 && guard <= 100) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
    end
    repeat (3) @(negedge clk);
    check("ld_reg_count", 64'(n_ld), 64'(n_acc - n_abort));
    summary();
  end

endmodule
